cpu_alu: RTL and testbench
==========================

Name: cpu_alu

Overview:
- 8-bit arithmetic/logic unit for the 6502-compatible (NES) CPU core.
- Performs add, subtract, AND, OR, XOR and shift-right on two 8-bit operands, with optional BCD correction for add and subtract.
- Produces registered result plus carry, overflow, zero and sign flags, which the CPU writes into status register P (C=P[0], Z=P[1], V=P[6], N=P[7]).
- Operands come from the CPU's alu_a/alu_b holding registers; the result drives the internal data bus.

Parameters:
- None. Datapath is fixed at 8 bits; the BCD logic depends on this.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  reset; one clock; reset is synchronous and active-high
- alu_a  input  8  operand A
- alu_b  input  8  operand B
- mode  input  5  operation select: 0=ADD, 1=AND, 2=OR, 3=EOR, 4=SR, 5=SUB; 6..31 reserved
- carry_in  input  1  carry input: ADD carry, SUB not-borrow, SR fill bit
- decimal_en  input  1  BCD mode; affects ADD and SUB only
- alu_out  output  8  registered result
- carry_out  output  1  registered carry / not-borrow / shifted-out bit
- overflow  output  1  registered signed overflow
- zero  output  1  registered, 1 when the binary result is 0x00
- sign  output  1  registered, bit 7 of the binary result

Behaviour:
- Pipeline: combinational compute from current inputs, captured at the rising edge. Latency is exactly 1 cycle. No handshake; new inputs are accepted every cycle.
- Reset: if rst=1 at an edge, all outputs are cleared to 0 (alu_out=0x00, carry_out=overflow=zero=sign=0). Reset wins over any operation in flight; the first valid result appears one cycle after rst deasserts.
- Binary arithmetic:
  - ADD: r = a + b + carry_in (9-bit). carry_out = r[8]. overflow = (a[7]==b[7]) && (r[7]!=a[7]).
  - SUB: r = a + ~b + carry_in, 6502 convention: carry_in=1 means no borrow, carry_out=1 means no borrow. overflow = (a[7]!=b[7]) && (r[7]!=a[7]).
- AND/OR/EOR: bitwise result; carry_out=0, overflow=0.
- SR: alu_out = {carry_in, a[7:1]}; carry_out = a[0]; overflow=0; alu_b is ignored. LSR uses carry_in=0, ROR uses carry_in=C. ASL/ROL are done by the CPU through ADD with a=b.
- Reserved modes: alu_out=0x00, carry_out=0, overflow=0, zero=1, sign=0.
- Decimal ADD (decimal_en=1):
  - Low nibble: lo = a[3:0] + b[3:0] + carry_in; if lo > 9, add 6 and set half-carry.
  - High nibble: hi = a[7:4] + b[7:4] + half-carry; if hi > 9, add 6 and set carry_out.
  - alu_out = {hi[3:0], lo[3:0]}.
- Decimal SUB (decimal_en=1):
  - Compute binary subtract. If the low-nibble borrow occurred, subtract 6 from the low nibble.
  - If the binary carry_out is 0, subtract 0x60.
  - carry_out = binary carry_out.
- Flags in decimal mode: zero, sign and overflow are always taken from the binary result (NMOS behaviour); decimal_en changes only alu_out and carry_out.
- Invalid BCD inputs: no error is raised; the result follows the same nibble rules.

Decomposition:
- cpu_pkg holds the ALU mode constants (ALU_ADD=0, ALU_AND=1, ALU_OR=2, ALU_EOR=3, ALU_SR=4, ALU_SUB=5), shared with the CPU controller. Mode is typed as 5 bits.
- One combinational sub-module, cpu_alu_bcd_adj, takes the binary sum, nibble carries and op, and returns the corrected byte and carry. Everything else lives in cpu_alu.

Test Plan:
- ADD 0x50+0x50, cin=0, dec=0 -> next cycle alu_out=0xA0, C=0, V=1, N=1, Z=0. Then ADD 0xFF+0x01, cin=0 -> 0x00, C=1, V=0, Z=1, N=0.
- SUB 0x50-0xB0, cin=1 -> 0xA0, C=0, V=1, N=1. Then SUB 0x40-0x40, cin=1 -> 0x00, C=1, Z=1.
- Logic with a=0xF0, b=0x3C: AND -> 0x30; OR -> 0xFC, N=1; EOR -> 0xCC. All with C=0, V=0.
- SR a=0x81, cin=1 -> 0xC0, C=1, N=1. SR a=0x01, cin=0 -> 0x00, C=1, Z=1.
- Decimal ADD 0x58+0x46, cin=1 -> 0x05, C=1. Decimal SUB 0x46-0x12, cin=1 -> 0x34, C=1. Decimal SUB 0x12-0x21, cin=1 -> 0x91, C=0.
- Back-to-back ops each cycle produce results on consecutive cycles. Assert rst while an ADD is presented -> all outputs 0 at that edge. Reserved mode 7 -> alu_out=0x00, Z=1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU operation codes and the ALU result record.
package cpu_pkg;

  localparam int ALU_W = 8;

  typedef logic [4:0] alu_mode_t;

  localparam alu_mode_t ALU_ADD = 5'd0;
  localparam alu_mode_t ALU_AND = 5'd1;
  localparam alu_mode_t ALU_OR  = 5'd2;
  localparam alu_mode_t ALU_EOR = 5'd3;
  localparam alu_mode_t ALU_SR  = 5'd4;
  localparam alu_mode_t ALU_SUB = 5'd5;

  // Result byte plus the four flags destined for P (C, V, Z, N).
  typedef struct packed {
    logic [ALU_W-1:0] res;
    logic             c;
    logic             v;
    logic             z;
    logic             n;
  } alu_res_t;

endpackage

// File: rtl/cpu_alu_bcd_adj.sv
// Decimal (BCD) correction for ADD/SUB. Purely combinational; works on the
// binary sum already formed by the ALU so the adder is shared.
module cpu_alu_bcd_adj
  import cpu_pkg::*;
(
  input  logic       i_sub,       // 1 = subtract, 0 = add
  input  logic [8:0] i_bin_sum,   // a + b (or a + ~b) + carry_in
  input  logic [4:0] i_lo_sum,    // low-nibble sum with its carry in bit 4
  input  logic [3:0] i_a_hi,      // operand high nibbles, used by the add path
  input  logic [3:0] i_b_hi,
  output logic [7:0] o_res,
  output logic       o_carry
);

  logic       w_hc;
  logic [4:0] w_lo_adj;
  logic [4:0] w_hi_sum;
  logic       w_hi_c;
  logic [4:0] w_hi_adj;
  logic [3:0] w_lo_sub;
  logic [7:0] w_sub_res;

  // Nibble-wise decimal correction for both directions; op selects the output.
  always_comb begin
    // Add: decide half-carry on the uncorrected low nibble, then ripple it up.
    w_hc     = (i_lo_sum > 5'd9);
    w_lo_adj = i_lo_sum + (w_hc ? 5'd6 : 5'd0);
    w_hi_sum = {1'b0, i_a_hi} + {1'b0, i_b_hi} + {4'b0, w_hc};
    w_hi_c   = (w_hi_sum > 5'd9);
    w_hi_adj = w_hi_sum + (w_hi_c ? 5'd6 : 5'd0);

    // Sub: a missing low-nibble carry is a borrow; the nibble wraps by 16,
    // so taking 6 off within the nibble lands on the right BCD digit.
    w_lo_sub  = i_bin_sum[3:0] - (i_lo_sum[4] ? 4'd0 : 4'd6);
    w_sub_res = {i_bin_sum[7:4], w_lo_sub} - (i_bin_sum[8] ? 8'h00 : 8'h60);

    if (i_sub) begin
      o_res   = w_sub_res;
      o_carry = i_bin_sum[8];
    end else begin
      o_res   = {w_hi_adj[3:0], w_lo_adj[3:0]};
      o_carry = w_hi_c;
    end
  end

endmodule

// File: rtl/cpu_alu.sv
// 8-bit 6502-style ALU: ADD/SUB (optionally BCD), AND/OR/EOR, shift right.
// Result and flags are registered; one cycle latency, new op every cycle.
module cpu_alu
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] alu_a,
  input  logic [7:0] alu_b,
  input  logic [4:0] mode,
  input  logic       carry_in,
  input  logic       decimal_en,
  output logic [7:0] alu_out,
  output logic       carry_out,
  output logic       overflow,
  output logic       zero,
  output logic       sign
);

  logic       w_sub;
  logic [7:0] w_b_eff;
  logic [8:0] w_bin;
  logic [4:0] w_lo;
  logic       w_bin_v;
  logic [7:0] w_bcd_res;
  logic       w_bcd_c;
  alu_res_t   w_nxt;
  alu_res_t   r_res;

  // Shared adder: SUB is a + ~b + carry_in, carry_in=1 meaning no borrow.
  assign w_sub   = (mode == ALU_SUB);
  assign w_b_eff = w_sub ? ~alu_b : alu_b;
  assign w_bin   = {1'b0, alu_a} + {1'b0, w_b_eff} + {8'b0, carry_in};
  assign w_lo    = {1'b0, alu_a[3:0]} + {1'b0, w_b_eff[3:0]} + {4'b0, carry_in};
  // Signed overflow: effective operands agree in sign but the result does not.
  assign w_bin_v = (alu_a[7] == w_b_eff[7]) && (w_bin[7] != alu_a[7]);

  cpu_alu_bcd_adj u_bcd_adj (
    .i_sub     (w_sub),
    .i_bin_sum (w_bin),
    .i_lo_sum  (w_lo),
    .i_a_hi    (alu_a[7:4]),
    .i_b_hi    (alu_b[7:4]),
    .o_res     (w_bcd_res),
    .o_carry   (w_bcd_c)
  );

  // Select result and flags; in decimal mode only the byte and carry change,
  // Z/N/V stay on the binary sum as the NMOS part does.
  always_comb begin
    w_nxt = '0;
    case (mode)
      ALU_ADD, ALU_SUB: begin
        w_nxt.res = decimal_en ? w_bcd_res : w_bin[7:0];
        w_nxt.c   = decimal_en ? w_bcd_c   : w_bin[8];
        w_nxt.v   = w_bin_v;
        w_nxt.z   = (w_bin[7:0] == 8'h00);
        w_nxt.n   = w_bin[7];
      end
      ALU_AND, ALU_OR, ALU_EOR: begin
        if (mode == ALU_AND)     w_nxt.res = alu_a & alu_b;
        else if (mode == ALU_OR) w_nxt.res = alu_a | alu_b;
        else                     w_nxt.res = alu_a ^ alu_b;
        w_nxt.z = (w_nxt.res == 8'h00);
        w_nxt.n = w_nxt.res[7];
      end
      ALU_SR: begin
        w_nxt.res = {carry_in, alu_a[7:1]};
        w_nxt.c   = alu_a[0];
        w_nxt.z   = (w_nxt.res == 8'h00);
        w_nxt.n   = carry_in;
      end
      default: begin
        // Reserved codes yield a clean zero result.
        w_nxt.z = 1'b1;
      end
    endcase
  end

  // Output register; reset clears result and all flags.
  always_ff @(posedge clk) begin
    if (rst) r_res <= '0;
    else     r_res <= w_nxt;
  end

  assign alu_out   = r_res.res;
  assign carry_out = r_res.c;
  assign overflow  = r_res.v;
  assign zero      = r_res.z;
  assign sign      = r_res.n;

endmodule

// File: tb/tb_cpu_alu.sv
// Directed bench for cpu_alu: a vector table applied back-to-back plus
// hand sequences around reset and reserved modes.
module tb_cpu_alu;
  import cpu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] alu_a, alu_b;
  logic [4:0] mode;
  logic       carry_in, decimal_en;
  logic [7:0] alu_out;
  logic       carry_out, overflow, zero, sign;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpu_alu dut (
    .clk        (clk),
    .rst        (rst),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .mode       (mode),
    .carry_in   (carry_in),
    .decimal_en (decimal_en),
    .alu_out    (alu_out),
    .carry_out  (carry_out),
    .overflow   (overflow),
    .zero       (zero),
    .sign       (sign)
  );

  typedef struct packed {
    logic [4:0] md;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       dec;
    logic [7:0] out;
    logic       c, v, z, n;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  task automatic check(input string nm, input logic [7:0] eo,
                       input logic ec, input logic ev, input logic ez, input logic en);
    checks++;
    if ({alu_out, carry_out, overflow, zero, sign} !== {eo, ec, ev, ez, en}) begin
      errors++;
      $display("FAIL %s: got out=%h c=%b v=%b z=%b n=%b, want out=%h c=%b v=%b z=%b n=%b",
               nm, alu_out, carry_out, overflow, zero, sign, eo, ec, ev, ez, en);
    end
  endtask

  task automatic drive(input logic [4:0] md, input logic [7:0] a, input logic [7:0] b,
                       input logic cin, input logic dec);
    mode = md; alu_a = a; alu_b = b; carry_in = cin; decimal_en = dec;
  endtask

  initial begin
    //             mode     a      b      cin  dec   out    c     v     z     n
    vecs[0]  = '{ALU_ADD, 8'h50, 8'h50, 1'b0, 1'b0, 8'hA0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[1]  = '{ALU_ADD, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{ALU_SUB, 8'h50, 8'hB0, 1'b1, 1'b0, 8'hA0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[3]  = '{ALU_SUB, 8'h40, 8'h40, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{ALU_AND, 8'hF0, 8'h3C, 1'b1, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{ALU_OR,  8'hF0, 8'h3C, 1'b0, 1'b0, 8'hFC, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{ALU_EOR, 8'hF0, 8'h3C, 1'b1, 1'b0, 8'hCC, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{ALU_SR,  8'h81, 8'hFF, 1'b1, 1'b0, 8'hC0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{ALU_SR,  8'h01, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
    // Decimal: flags Z/N/V from the binary sum (0x58+0x46+1 = 0x9F).
    vecs[9]  = '{ALU_ADD, 8'h58, 8'h46, 1'b1, 1'b1, 8'h05, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[10] = '{ALU_SUB, 8'h46, 8'h12, 1'b1, 1'b1, 8'h34, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{ALU_SUB, 8'h12, 8'h21, 1'b1, 1'b1, 8'h91, 1'b0, 1'b0, 1'b0, 1'b1};
    // Low-nibble borrow: binary 0x0F, corrected to 0x09.
    vecs[12] = '{ALU_SUB, 8'h10, 8'h01, 1'b1, 1'b1, 8'h09, 1'b1, 1'b0, 1'b0, 1'b0};
    // 99+01 decimal -> 00 C=1, but Z/N follow binary 0x9A.
    vecs[13] = '{ALU_ADD, 8'h99, 8'h01, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1};
    // decimal_en has no effect on logic ops.
    vecs[14] = '{ALU_AND, 8'h99, 8'h0F, 1'b1, 1'b1, 8'h09, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{5'd7,    8'h55, 8'hAA, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[16] = '{5'd31,   8'hFF, 8'hFF, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};

    rst = 1'b1;
    drive(ALU_ADD, 8'h50, 8'h50, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 check("reset_state", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // Back-to-back: one new vector per cycle, result checked 1 cycle later.
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].md, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].dec);
      @(posedge clk);
      #1 check($sformatf("vec%0d", i), vecs[i].out, vecs[i].c, vecs[i].v, vecs[i].z, vecs[i].n);
    end

    // Reset while a flag-setting ADD is presented.
    drive(ALU_ADD, 8'hFF, 8'h01, 1'b0, 1'b0);
    @(posedge clk);
    #1 check("pre_rst_add", 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    drive(ALU_ADD, 8'h50, 8'h50, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1 check("rst_over_add", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1 check("after_rst_add", 8'hA0, 1'b0, 1'b1, 1'b0, 1'b1);

    // Output holds the registered value, not the live inputs.
    drive(ALU_OR, 8'h00, 8'h00, 1'b0, 1'b0);
    #2 check("latency_hold", 8'hA0, 1'b0, 1'b1, 1'b0, 1'b1);
    @(posedge clk);
    #1 check("or_zero", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no completion, want finish before 100000");
    $fatal(1);
  end

endmodule
